gps_channel_wb_regs: RTL and testbench
======================================

// Module: gps_channel_wb_regs
// PURPOSE
//  Wishbone slave register bank for one GPS tracking channel; the responder the bus master talks to.
//  Holds NCO words, offsets, threshold and config as flops feeding the correlator.
//  Snapshots the six I/Q accumulators on each dump strobe and exposes them, with a ready/overrun status, for CPU polling.
// PARAMETERS
//  BASE_ADDR  32'h00000A00  channel page base; only adr[31:8] is compared
//  AW         32            Wishbone address width
//  DW         32            Wishbone data width (fixed 32)
// PORTS
//  wb_clk_i      in   1   sole clock (bus and register domain)
//  wb_rst_i      in   1   asynchronous, active-low reset
//  wb_adr_i      in   AW  byte address
//  wb_dat_i      in   DW  write data
//  wb_sel_i      in   4   byte enables
//  wb_we_i       in   1   1 = write
//  wb_stb_i      in   1   strobe
//  wb_cyc_i      in   1   cycle valid
//  wb_dat_o      out  DW  read data
//  wb_ack_o      out  1   transfer acknowledge
//  code_freq_o   out  32  reg 0x00 code NCO word
//  carr_freq_o   out  32  reg 0x04 carrier NCO word
//  code_off_o    out  32  reg 0x08 code NCO offset
//  carr_off_o    out  32  reg 0x0C carrier NCO offset
//  acq_thresh_o  out  32  reg 0x10 acquisition threshold
//  config_o      out  32  reg 0x14 config ([31:24] SV id, rest opaque to this block)
//  cfg_load_o    out  1   1-cycle pulse after any write to 0x14
//  dump_i        in   1   1-cycle dump strobe, already in wb_clk_i domain
//  acc_ip_i, acc_qp_i, acc_il_i, acc_ql_i, acc_ie_i, acc_qe_i  in 32 each  live accumulators
//  dump_ready_o  out  1   mirrors STATUS[0]
// BEHAVIOUR
//  Reset: all registers, snapshots, STATUS, wb_ack_o, wb_dat_o, cfg_load_o = 0.
//  Select: sel = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]) & ~wb_ack_o. Non-matching page: no ack, no effect.
//  Ack: registered; wb_ack_o high exactly 1 cycle after sel, then low >=1 cycle (no back-to-back ack).
//  Write (sel & we): byte lanes per wb_sel_i to RW regs 0x00-0x14; takes effect with the ack edge.
//  Read (sel & ~we): wb_dat_o registered alongside ack; 0x18 IP, 0x1C QP, 0x20 IL, 0x24 QL, 0x28 IE, 0x2C QE snapshots; 0x30 STATUS.
//  Unmapped offsets (incl. 0x34-0xFF, non-word-aligned adr[1:0] ignored): read 0, ack, writes dropped.
//  Writes to 0x18-0x2C ignored (acked).
//  STATUS: [0] READY, [1] OVERRUN, [31:2] read 0.
//   dump_i & ~READY: capture all six acc_*_i into snapshots same edge; READY<=1.
//   dump_i & READY: snapshots held (CPU data protected); OVERRUN<=1 (sticky).
//   Write to 0x30 with sel[0]: data bit0==0 clears READY, bit1==0 clears OVERRUN; 1 bits no effect.
//   Simultaneous READY clear and dump_i: dump wins; snapshot updated, READY stays 1, no OVERRUN.
//  cfg_load_o: asserted the cycle after the 0x14 write ack edge, 1 cycle wide.
//  Reset asserted mid-transfer: ack drops asynchronously; master must reissue.
// TESTING
//  Reset: drive wb_rst_i=0 -> all outputs 0; release, read 0x00..0x30 -> all 0x00000000.
//  Write 0xA04=0x16EA4A8C then read -> carr_freq_o and readback 0x16EA4A8C, ack 1 cycle wide, 1-cycle latency.
//  wb_sel_i=4'b0010 write 0xFFFFFFFF to 0xA10 holding 0x00002710 -> 0x0000FF10.
//  acc_ip_i=0x123, dump_i pulse -> STATUS=1, 0xA18 reads 0x123; change acc_ip_i, 2nd dump -> STATUS=3, 0xA18 still 0x123.
//  Write 0 to 0xA30 same cycle as dump_i -> STATUS[0]=1, snapshot = new value, OVERRUN unchanged.
//  Access 0xB04 -> no ack within 8 cycles; write 0xA14 -> cfg_load_o one pulse; read 0xA40 -> 0, acked.

Source files
------------

// File: rtl/gps_channel_wb_regs.sv
// Wishbone register page for one GPS tracking channel: NCO/config words out, dump-time I/Q snapshots in.
// One-cycle registered ack per selected access, never back-to-back; the bus is never stalled beyond that.
module gps_channel_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0A00,
    parameter int          AW        = 32,
    parameter int          DW        = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic [31:0]   code_freq_o,
    output logic [31:0]   carr_freq_o,
    output logic [31:0]   code_off_o,
    output logic [31:0]   carr_off_o,
    output logic [31:0]   acq_thresh_o,
    output logic [31:0]   config_o,
    output logic          cfg_load_o,
    input  logic          dump_i,
    input  logic [31:0]   acc_ip_i,
    input  logic [31:0]   acc_qp_i,
    input  logic [31:0]   acc_il_i,
    input  logic [31:0]   acc_ql_i,
    input  logic [31:0]   acc_ie_i,
    input  logic [31:0]   acc_qe_i,
    output logic          dump_ready_o
);

    localparam logic [5:0] WORD_CFG    = 6'd5;
    localparam logic [5:0] WORD_STATUS = 6'd12;

    logic [31:0] rw_q   [6];
    logic [31:0] snap_q [6];
    logic [31:0] acc    [6];
    logic        ready_q;
    logic        overrun_q;

    logic        sel;
    logic        wr_en;
    logic [5:0]  word;
    logic [31:0] rd_dat;
    logic        clr_ready;
    logic        clr_overrun;
    logic        ready_eff;

    assign acc[0] = acc_ip_i;
    assign acc[1] = acc_qp_i;
    assign acc[2] = acc_il_i;
    assign acc[3] = acc_ql_i;
    assign acc[4] = acc_ie_i;
    assign acc[5] = acc_qe_i;

    // ~wb_ack_o in the select guarantees at least one idle cycle between acks
    assign sel   = wb_cyc_i & wb_stb_i & (wb_adr_i[AW-1:8] == BASE_ADDR[AW-1:8]) & ~wb_ack_o;
    assign wr_en = sel & wb_we_i;
    assign word  = wb_adr_i[7:2];

    assign clr_ready   = wr_en & (word == WORD_STATUS) & wb_sel_i[0] & ~wb_dat_i[0];
    assign clr_overrun = wr_en & (word == WORD_STATUS) & wb_sel_i[0] & ~wb_dat_i[1];
    // A clear landing on the same edge as a dump frees the buffer for that dump
    assign ready_eff   = ready_q & ~clr_ready;

    always_comb begin
        rd_dat = '0;
        for (int r = 0; r < 6; r++) begin
            if (word == 6'(r))     rd_dat = rw_q[r];
            if (word == 6'(r + 6)) rd_dat = snap_q[r];
        end
        if (word == WORD_STATUS) rd_dat = {30'd0, overrun_q, ready_q};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            cfg_load_o <= 1'b0;
            for (int r = 0; r < 6; r++) rw_q[r] <= '0;
        end else begin
            wb_ack_o   <= sel;
            wb_dat_o   <= (sel & ~wb_we_i) ? rd_dat : '0;
            cfg_load_o <= wr_en & (word == WORD_CFG);
            for (int r = 0; r < 6; r++)
                for (int b = 0; b < 4; b++)
                    if (wr_en && word == 6'(r) && wb_sel_i[b])
                        rw_q[r][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int r = 0; r < 6; r++) snap_q[r] <= '0;
        end else begin
            overrun_q <= (overrun_q & ~clr_overrun) | (dump_i & ready_eff);
            if (dump_i && !ready_eff) begin
                ready_q <= 1'b1;
                for (int r = 0; r < 6; r++) snap_q[r] <= acc[r];
            end else begin
                ready_q <= ready_eff;
            end
        end
    end

    assign code_freq_o  = rw_q[0];
    assign carr_freq_o  = rw_q[1];
    assign code_off_o   = rw_q[2];
    assign carr_off_o   = rw_q[3];
    assign acq_thresh_o = rw_q[4];
    assign config_o     = rw_q[5];
    assign dump_ready_o = ready_q;

endmodule

// File: tb/tb_gps_channel_wb_regs.sv
// Directed bench for the GPS channel Wishbone register page.
module tb_gps_channel_wb_regs;

    logic        gps_clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_cyc, wb_ack;
    logic [31:0] code_freq, carr_freq, code_off, carr_off, acq_thresh, config_w;
    logic        cfg_load, dump, dump_ready;
    logic [31:0] acc_ip, acc_qp, acc_il, acc_ql, acc_ie, acc_qe;

    int total = 0;
    int bad   = 0;
    int cfg_cnt = 0;
    logic [31:0] rd;
    int          lat;
    logic        ack_after;

    always #5 gps_clk = ~gps_clk;

    gps_channel_wb_regs dut (
        .wb_clk_i(gps_clk), .wb_rst_i(rst_n),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
        .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
        .code_freq_o(code_freq), .carr_freq_o(carr_freq), .code_off_o(code_off),
        .carr_off_o(carr_off), .acq_thresh_o(acq_thresh), .config_o(config_w),
        .cfg_load_o(cfg_load), .dump_i(dump),
        .acc_ip_i(acc_ip), .acc_qp_i(acc_qp), .acc_il_i(acc_il),
        .acc_ql_i(acc_ql), .acc_ie_i(acc_ie), .acc_qe_i(acc_qe),
        .dump_ready_o(dump_ready)
    );

    always @(negedge gps_clk) if (cfg_load) cfg_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one transfer starting just after a clock edge; lat = cycles to ack or -1 after 8 cycles.
    // When with_dump is set, dump_i is pulsed on the same edge that samples the request.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input logic with_dump,
                           output logic [31:0] rdat, output int latency, output logic ack_next);
        wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_w = dat;
        wb_cyc = 1'b1; wb_stb = 1'b1; dump = with_dump;
        latency = -1; rdat = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge gps_clk); #1;
            dump = 1'b0;
            if (wb_ack) begin
                latency = n; rdat = wb_dat_r;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge gps_clk); #1;
        ack_next = wb_ack;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d; int l; logic a;
        wb_xfer(adr, 1'b0, 4'hF, 32'h0, 1'b0, d, l, a);
        chk({tag, "_lat"}, 32'(l), 32'd1);
        chk(tag, d, exp);
    endtask

    task automatic dump_pulse();
        dump = 1'b1;
        @(posedge gps_clk); #1;
        dump = 1'b0;
        @(posedge gps_clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; dump = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 0; wb_stb = 0; wb_cyc = 0;
        acc_ip = '0; acc_qp = '0; acc_il = '0; acc_ql = '0; acc_ie = '0; acc_qe = '0;
        #23;
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_dat", wb_dat_r, 32'd0);
        chk("rst_outs", code_freq | carr_freq | code_off | carr_off | acq_thresh | config_w, 32'd0);
        chk("rst_flags", {30'd0, cfg_load, dump_ready}, 32'd0);
        @(negedge gps_clk); rst_n = 1'b1;
        @(posedge gps_clk); #1;
        for (int a = 0; a <= 12; a++)
            rd_chk($sformatf("rst_rd_%0h", 32'hA00 + 4 * a), 32'hA00 + 32'(4 * a), 32'h0);

        // full-word write with latency and ack-width checks
        wb_xfer(32'hA04, 1'b1, 4'hF, 32'h16EA4A8C, 1'b0, rd, lat, ack_after);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_ack_width", {31'd0, ack_after}, 32'd0);
        chk("carr_freq_o", carr_freq, 32'h16EA4A8C);
        rd_chk("carr_rd", 32'hA04, 32'h16EA4A8C);
        rd_chk("carr_rd_unaligned", 32'hA06, 32'h16EA4A8C);

        // byte-lane write
        wb_xfer(32'hA10, 1'b1, 4'hF, 32'h00002710, 1'b0, rd, lat, ack_after);
        wb_xfer(32'hA10, 1'b1, 4'b0010, 32'hFFFFFFFF, 1'b0, rd, lat, ack_after);
        chk("thresh_o", acq_thresh, 32'h0000FF10);
        rd_chk("thresh_rd", 32'hA10, 32'h0000FF10);

        // first dump captures, second sets overrun and holds data
        acc_ip = 32'h123; acc_qe = 32'hDEAD_BEEF;
        dump_pulse();
        rd_chk("status_1", 32'hA30, 32'd1);
        chk("dump_ready_o", {31'd0, dump_ready}, 32'd1);
        rd_chk("snap_ip", 32'hA18, 32'h123);
        rd_chk("snap_qe", 32'hA2C, 32'hDEAD_BEEF);
        acc_ip = 32'h456;
        dump_pulse();
        rd_chk("status_ovr", 32'hA30, 32'd3);
        rd_chk("snap_held", 32'hA18, 32'h123);

        // snapshot writes are dropped but acked
        wb_xfer(32'hA18, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, rd, lat, ack_after);
        chk("snap_wr_lat", 32'(lat), 32'd1);
        rd_chk("snap_wr_ignored", 32'hA18, 32'h123);

        // clear READY only (bit1 kept) racing a dump
        acc_ip = 32'h789;
        wb_xfer(32'hA30, 1'b1, 4'b0001, 32'h2, 1'b1, rd, lat, ack_after);
        rd_chk("race_keep_ovr", 32'hA30, 32'd3);
        rd_chk("race_snap1", 32'hA18, 32'h789);

        // clear all, dump, then write 0 racing a dump: dump wins, no overrun
        wb_xfer(32'hA30, 1'b1, 4'b0001, 32'h0, 1'b0, rd, lat, ack_after);
        rd_chk("status_clr", 32'hA30, 32'd0);
        acc_ip = 32'hAAA;
        dump_pulse();
        acc_ip = 32'hBBB;
        wb_xfer(32'hA30, 1'b1, 4'b0001, 32'h0, 1'b1, rd, lat, ack_after);
        rd_chk("race_status", 32'hA30, 32'd1);
        rd_chk("race_snap2", 32'hA18, 32'hBBB);

        // wrong page: never acked, no effect
        wb_xfer(32'hB04, 1'b1, 4'hF, 32'h5555_5555, 1'b0, rd, lat, ack_after);
        chk("page_miss_lat", 32'(lat), 32'hFFFF_FFFF);
        chk("page_miss_noeff", carr_freq, 32'h16EA4A8C);

        // config write produces exactly one load pulse
        cfg_cnt = 0;
        wb_xfer(32'hA14, 1'b1, 4'hF, 32'hAB00_0001, 1'b0, rd, lat, ack_after);
        repeat (4) @(posedge gps_clk);
        #1;
        chk("cfg_load_cnt", 32'(cfg_cnt), 32'd1);
        chk("config_o", config_w, 32'hAB00_0001);

        rd_chk("unmapped_rd", 32'hA40, 32'h0);
        wb_xfer(32'hA3C, 1'b1, 4'hF, 32'h1234_5678, 1'b0, rd, lat, ack_after);
        chk("unmapped_wr_lat", 32'(lat), 32'd1);
        rd_chk("unmapped_wr_rd", 32'hA3C, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
